// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I core front end.
package core_pkg;
    typedef enum logic [1:0] {REQ, WAIT, HOLD, ERR} fetch_state_t;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection (jalr > branch/jal > sequential) and alignment check.
module pc_next (
    input  logic [31:0] PC,
    input  logic [31:0] ImmOp,
    input  logic [31:0] ALUResult,
    input  logic        PCsrc,
    input  logic        JUMPRT,
    output logic [31:0] next_pc,
    output logic        misaligned
);
    assign next_pc    = JUMPRT ? (ALUResult & ~32'd1) : PCsrc ? PC + ImmOp : PC + 32'd4;
    assign misaligned = |next_pc[1:0];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one imem read at a time and hands the word to the core.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        PCsrc,
    input  logic        JUMPRT,
    input  logic [31:0] ImmOp,
    input  logic [31:0] ALUResult,
    output logic        fetch_misaligned,
    output logic [31:0] fetch_count
);
    import core_pkg::*;
    fetch_state_t r_state, w_next_state;
    logic [31:0] r_pc, r_pc4, r_instr, r_count, w_next_pc;
    logic        w_mis, w_hs;
    pc_next u_pc_next (
        .PC(r_pc), .ImmOp(ImmOp), .ALUResult(ALUResult), .PCsrc(PCsrc), .JUMPRT(JUMPRT),
        .next_pc(w_next_pc), .misaligned(w_mis)
    );
    assign w_hs = (r_state == HOLD) && instr_ready;
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            REQ:     w_next_state = WAIT;
            WAIT:    w_next_state = imem_rvalid ? HOLD : WAIT;
            HOLD:    w_next_state = instr_ready ? (w_mis ? ERR : REQ) : HOLD;
            default: w_next_state = ERR;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
            r_pc4   <= RESET_PC + 32'd4;
            r_instr <= NOP_INSTR;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == WAIT && imem_rvalid) r_instr <= imem_rdata;
            if (w_hs && !w_mis) begin
                r_pc    <= w_next_pc;
                r_pc4   <= w_next_pc + 32'd4;
                r_count <= r_count + 32'd1;
            end
        end
    end
    // rst gates the request so nothing is issued while memory is also held in reset
    assign imem_req         = (r_state == REQ) && !rst;
    assign imem_addr        = r_pc;
    assign instr            = r_instr;
    assign instr_valid      = (r_state == HOLD);
    assign PC               = r_pc;
    assign PCPlus4          = r_pc4;
    assign fetch_misaligned = (r_state == ERR);
    assign fetch_count      = r_count;
endmodule
